// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared BTB constants, entry/update types and PC field helpers
package btb_pkg;

  localparam int ADDR_BITS    = 32;
  localparam int BTB_SETS     = 16;
  localparam int BTB_TAG_BITS = 8;
  localparam int BTB_IDX_BITS = $clog2(BTB_SETS);

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [ADDR_BITS-1:0]    target;
  } btb_entry_t;

  typedef struct packed {
    logic                    valid;
    logic [BTB_IDX_BITS-1:0] idx;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [ADDR_BITS-1:0]    target;
  } btb_update_t;

  function automatic logic [BTB_IDX_BITS-1:0] pc_idx(input logic [ADDR_BITS-1:0] pc);
    return pc[BTB_IDX_BITS+1:2];
  endfunction

  function automatic logic [BTB_TAG_BITS-1:0] pc_tag(input logic [ADDR_BITS-1:0] pc);
    return pc[BTB_IDX_BITS+BTB_TAG_BITS+1:BTB_IDX_BITS+2];
  endfunction

endpackage

// File: rtl/btb_set_lookup.sv
// rtl/btb_set_lookup.sv - 2-way tag compare and target select for one set
module btb_set_lookup
  import btb_pkg::*;
(
  input  btb_entry_t              way0_i,
  input  btb_entry_t              way1_i,
  input  logic [BTB_TAG_BITS-1:0] tag_i,
  output logic                    hit_o,
  output logic                    hit_way_o,
  output logic [ADDR_BITS-1:0]    target_o
);

  logic hit0, hit1;

  assign hit0      = way0_i.valid && (way0_i.tag == tag_i);
  assign hit1      = way1_i.valid && (way1_i.tag == tag_i);
  assign hit_o     = hit0 | hit1;
  assign hit_way_o = ~hit0;
  assign target_o  = hit0 ? way0_i.target : (hit1 ? way1_i.target : '0);

endmodule

// File: rtl/btb.sv
// rtl/btb.sv - 2-way set-associative BTB with a bypassed one-entry training register
module btb
  import btb_pkg::*;
#(
  parameter int FETCH_WIDTH = 2
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  resolving_valid,
  input  logic [ADDR_BITS-1:0]                  resolving_branch_PC,
  input  logic [ADDR_BITS-1:0]                  resolving_target_PC,
  input  logic [FETCH_WIDTH-1:0][ADDR_BITS-1:0] lookup_PC,
  output logic [FETCH_WIDTH-1:0]                btb_hit,
  output logic [FETCH_WIDTH-1:0][ADDR_BITS-1:0] btb_target
);

  btb_entry_t             way0_q [BTB_SETS];
  btb_entry_t             way1_q [BTB_SETS];
  logic [BTB_SETS-1:0]    lru_q;
  btb_update_t            pend_q, pend_d;

  logic                   wr_hit, wr_hit_way, wr_way, wr_lru;
  logic [ADDR_BITS-1:0]   wr_hit_target;
  btb_entry_t             wr_entry;

  always_comb begin
    pend_d        = '0;
    pend_d.valid  = resolving_valid;
    pend_d.idx    = pc_idx(resolving_branch_PC);
    pend_d.tag    = pc_tag(resolving_branch_PC);
    pend_d.target = resolving_target_PC;
  end

  btb_set_lookup u_wr_lookup (
    .way0_i    (way0_q[pend_q.idx]),
    .way1_i    (way1_q[pend_q.idx]),
    .tag_i     (pend_q.tag),
    .hit_o     (wr_hit),
    .hit_way_o (wr_hit_way),
    .target_o  (wr_hit_target)
  );

  // Update-in-place on a tag hit keeps a set from ever holding the same tag twice.
  always_comb begin
    wr_way = 1'b0;
    wr_lru = 1'b0;
    if (wr_hit) begin
      wr_way = wr_hit_way;
      wr_lru = ~wr_hit_way;
    end else if (!way0_q[pend_q.idx].valid) begin
      wr_way = 1'b0;
      wr_lru = 1'b1;
    end else if (!way1_q[pend_q.idx].valid) begin
      wr_way = 1'b1;
      wr_lru = 1'b0;
    end else begin
      wr_way = lru_q[pend_q.idx];
      wr_lru = ~lru_q[pend_q.idx];
    end
  end

  always_comb begin
    wr_entry        = '0;
    wr_entry.valid  = 1'b1;
    wr_entry.tag    = pend_q.tag;
    wr_entry.target = pend_q.target;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q.valid <= 1'b0;
      lru_q        <= '0;
      for (int s = 0; s < BTB_SETS; s++) begin
        way0_q[s].valid <= 1'b0;
        way1_q[s].valid <= 1'b0;
      end
    end else begin
      pend_q <= pend_d;
      if (pend_q.valid) begin
        if (wr_way) way1_q[pend_q.idx] <= wr_entry;
        else        way0_q[pend_q.idx] <= wr_entry;
        lru_q[pend_q.idx] <= wr_lru;
      end
    end
  end

  for (genvar p = 0; p < FETCH_WIDTH; p++) begin : g_port
    logic [BTB_IDX_BITS-1:0] idx;
    logic [BTB_TAG_BITS-1:0] tag;
    logic                    tbl_hit, tbl_way, bypass;
    logic [ADDR_BITS-1:0]    tbl_target;

    assign idx = pc_idx(lookup_PC[p]);
    assign tag = pc_tag(lookup_PC[p]);

    btb_set_lookup u_lookup (
      .way0_i    (way0_q[idx]),
      .way1_i    (way1_q[idx]),
      .tag_i     (tag),
      .hit_o     (tbl_hit),
      .hit_way_o (tbl_way),
      .target_o  (tbl_target)
    );

    // The pending update is newer than anything in the table, so it wins.
    assign bypass        = pend_q.valid && (pend_q.idx == idx) && (pend_q.tag == tag);
    assign btb_hit[p]    = bypass | tbl_hit;
    assign btb_target[p] = bypass ? pend_q.target : tbl_target;
  end

endmodule
